sparse_mask_decomp: RTL and testbench
=====================================

// Module: sparse_mask_decomp
// PURPOSE
//  Parametrised bitmask-sparse decompressor, successor to the fixed 8-bit AXIS decompressor.
//  Packed nonzero elements arrive on the input stream and one LANES-bit mask per output beat
//  arrives on a mask stream. The block counts mask bits, takes that many elements from a
//  residual buffer, and scatters them into a dense DATA_W beat on the c2s AXIS output.
//  Adds selectable element width, a separate mask channel, underrun/leftover detection and full backpressure.
// PARAMETERS
//  DATA_W  256  input/output tdata width in bits; multiple of ELEM_W
//  ELEM_W  8    element width in bits; one of 8, 16, 32
//  LANES   DATA_W/ELEM_W  derived; elements per beat and mask width (localparam)
// PORTS
//  axis_aclk          in   1         single clock; all logic on rising edge
//  axis_areset        in   1         asynchronous, active-high reset
//  axis_tdata         in   DATA_W    packed nonzero elements, element 0 in bits [ELEM_W-1:0]
//  axis_tkeep         in   DATA_W/8  byte enables; contiguous from bit 0; all ones except on tlast beat
//  axis_tvalid        in   1         input data valid
//  axis_tready        out  1         input data ready
//  axis_tlast         in   1         last packed data beat of the frame
//  axis_mask_tdata    in   LANES     mask bit i=1 -> output lane i takes the next packed element
//  axis_mask_tvalid   in   1         mask valid
//  axis_mask_tready   out  1         mask ready (pulses on fire)
//  axis_mask_tlast    in   1         last mask of the frame
//  axis_tdata_c2s     out  DATA_W    dense output beat
//  axis_tkeep_c2s     out  DATA_W/8  all ones while axis_tvalid_c2s=1, else 0
//  axis_tvalid_c2s    out  1         output valid
//  axis_tready_c2s    in   1         output ready
//  axis_tlast_c2s     out  1         copy of the mask tlast for this beat
//  err_underrun       out  1         sticky; a mask fired with too few elements after input tlast
//  err_leftover       out  1         sticky; elements remained after mask tlast
// BEHAVIOUR
//  Reset: every output is 0. Buffer fill is 0, the in_done flag is cleared, and both sticky errors are cleared.
//   A reset mid-frame discards all buffered data and any held output beat. There is no recovery handshake.
//  Residual buffer: 2*LANES elements and a fill counter (0..2*LANES).
//   axis_tready = (fill - cnt_fire <= LANES) & ~in_done.
//   An accepted beat appends n_in = popcount(tkeep)/(ELEM_W/8) elements at index fill - cnt_fire.
//   An accepted beat with tlast sets in_done. in_done clears when a mask tlast fires.
//  cnt = popcount(axis_mask_tdata).
//  Fire condition: mask_tvalid & out_free & (fill >= cnt | in_done).
//   out_free = ~axis_tvalid_c2s | axis_tready_c2s.
//   axis_mask_tready = fire. A mask and a data beat may be accepted in the same cycle.
//  Scatter on fire: lane i = mask[i] ? buf[popcount(mask[i-1:0])] : 0.
//   If in_done and fill < cnt, mask lanes whose index >= fill read 0, and err_underrun is set.
//   The buffer shifts down by min(cnt, fill). Masks of 0 are legal: output is zeros and no element is consumed.
//  Output register: loaded on fire, so latency is 1 cycle from mask acceptance to axis_tvalid_c2s.
//   tdata/tlast hold stable while tvalid_c2s=1 & tready_c2s=0. Back-to-back fires give 1 beat per cycle.
//  Mask tlast fire: if fill - consumed + appended_this_cycle != 0, set err_leftover and set fill to 0.
//   Data accepted in that cycle belongs to the old frame and is discarded with it.
//  Arithmetic: fill and prefix counts are $clog2(2*LANES+1) bits. No wrap is possible, by the tready rule.
//  Illegal tkeep (non-contiguous, or partial without tlast) is undefined. The bench must not drive it.
// TESTING
//  T1 DATA_W=256, ELEM_W=8, data 0x01..0x20 full beat, mask 32'hFFFFFFFF -> out = input, tlast_c2s per mask.
//  T2 data bytes AA,BB,CC (tkeep=0x7, tlast), mask 32'h8000_0005 -> lane0=AA, lane2=BB, lane31=CC, other lanes 0.
//  T3 masks 0x0000000F x16 over 2 full data beats, tready_c2s toggling 1/0 -> 16 beats in order, no loss or duplication.
//  T4 data tlast after 3 elements, mask 0x0F with tlast -> lanes0-2 data, lane3=0, err_underrun=1.
//  T5 5 elements sent, mask 0x03 with tlast -> 2 lanes out, err_leftover=1, next frame decodes cleanly from fill=0.
//  T6 ELEM_W=32, DATA_W=128, mask 4'b1010 -> lane1, lane3 = elements 0, 1; reset asserted mid-frame -> all outputs 0.

Source files
------------

// File: rtl/sparse_mask_decomp.sv
// sparse_mask_decomp: bitmask-sparse AXIS decompressor; scatters buffered packed elements into dense beats
module sparse_mask_decomp #(
  parameter int DATA_W = 256,
  parameter int ELEM_W = 8
) (
  input  logic                     axis_aclk,
  input  logic                     axis_areset,
  input  logic [DATA_W-1:0]        axis_tdata,
  input  logic [DATA_W/8-1:0]      axis_tkeep,
  input  logic                     axis_tvalid,
  output logic                     axis_tready,
  input  logic                     axis_tlast,
  input  logic [DATA_W/ELEM_W-1:0] axis_mask_tdata,
  input  logic                     axis_mask_tvalid,
  output logic                     axis_mask_tready,
  input  logic                     axis_mask_tlast,
  output logic [DATA_W-1:0]        axis_tdata_c2s,
  output logic [DATA_W/8-1:0]      axis_tkeep_c2s,
  output logic                     axis_tvalid_c2s,
  input  logic                     axis_tready_c2s,
  output logic                     axis_tlast_c2s,
  output logic                     err_underrun,
  output logic                     err_leftover
);
  localparam int LANES = DATA_W / ELEM_W;
  localparam int N2 = 2 * LANES;
  localparam int CW = $clog2(N2 + 1);
  localparam int IW = $clog2(N2);
  localparam int EB = ELEM_W / 8;
  logic [ELEM_W-1:0] elem_q [N2];
  logic [ELEM_W-1:0] elem_d [N2];
  logic [CW-1:0] fill_q, fill_d;
  logic in_done_q, in_done_d, und_q, und_d, left_q, left_d;
  logic vld_q, vld_d, last_q, last_d;
  logic [DATA_W-1:0] out_q, out_d, lane;
  logic fire, acc, fin;
  int cnt, nin, f, cons, base, rem, pre, src, k, sel;
  always_comb begin
    cnt = 0;
    for (int i = 0; i < LANES; i++) cnt += int'(axis_mask_tdata[i]);
    nin = 0;
    for (int i = 0; i < DATA_W / 8; i++) nin += int'(axis_tkeep[i]);
    nin = nin / EB;
    f = int'(fill_q);
    fire = ~axis_areset & axis_mask_tvalid & (~vld_q | axis_tready_c2s) & ((f >= cnt) | in_done_q);
    cons = fire ? ((cnt < f) ? cnt : f) : 0;
    base = f - cons;
    axis_tready = ~axis_areset & ~in_done_q & (base <= LANES);
    acc = axis_tready & axis_tvalid;
    rem = base + (acc ? nin : 0);
    fin = fire & axis_mask_tlast;
    // a finished frame drops whatever is still buffered, including data accepted this cycle
    fill_d = fin ? '0 : CW'(rem);
    in_done_d = ~fin & (in_done_q | (acc & axis_tlast));
    und_d = und_q | (fire & in_done_q & (f < cnt));
    left_d = left_q | (fin & (rem != 0));
    vld_d = fire | (vld_q & ~axis_tready_c2s);
    last_d = fire ? axis_mask_tlast : last_q;
  end
  always_comb begin
    lane = '0;
    pre = 0;
    src = 0;
    k = 0;
    sel = 0;
    for (int i = 0; i < LANES; i++) begin
      lane[i*ELEM_W +: ELEM_W] = (axis_mask_tdata[i] && pre < f) ? elem_q[IW'(pre)] : '0;
      pre += int'(axis_mask_tdata[i]);
    end
    out_d = fire ? lane : out_q;
    // shift out consumed elements, then append the accepted beat behind the survivors
    for (int j = 0; j < N2; j++) begin
      src = j + cons;
      k = j - base;
      sel = (k >= 0 && k < nin) ? k : 0;
      elem_d[j] = (acc && k >= 0 && k < nin) ? axis_tdata[sel*ELEM_W +: ELEM_W] :
                  (src < N2) ? elem_q[IW'(src)] : '0;
    end
  end
  always_ff @(posedge axis_aclk or posedge axis_areset)
    if (axis_areset) begin
      fill_q <= '0;
      in_done_q <= 1'b0;
      und_q <= 1'b0;
      left_q <= 1'b0;
      vld_q <= 1'b0;
      last_q <= 1'b0;
      out_q <= '0;
      for (int j = 0; j < N2; j++) elem_q[j] <= '0;
    end else begin
      fill_q <= fill_d;
      in_done_q <= in_done_d;
      und_q <= und_d;
      left_q <= left_d;
      vld_q <= vld_d;
      last_q <= last_d;
      out_q <= out_d;
      for (int j = 0; j < N2; j++) elem_q[j] <= elem_d[j];
    end
  assign axis_mask_tready = fire;
  assign axis_tdata_c2s = out_q;
  assign axis_tkeep_c2s = {(DATA_W/8){vld_q}};
  assign axis_tvalid_c2s = vld_q;
  assign axis_tlast_c2s = last_q;
  assign err_underrun = und_q;
  assign err_leftover = left_q;
endmodule

// File: tb/tb_sparse_mask_decomp.sv
// tb_sparse_mask_decomp: randomized frames checked against a sequential element-consumption model
module tb_sparse_mask_decomp;
  localparam int DW = 256, L = 32, BW = 32;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [DW-1:0] tdata, odata;
  logic [BW-1:0] tkeep, okeep;
  logic tvalid, tready, tlast, mvalid, mready, mlast, ovalid, oready, olast, und, left;
  logic [L-1:0] mdata;
  logic [127:0] tdata2, odata2;
  logic [15:0] tkeep2, okeep2;
  logic tvalid2, tready2, tlast2, mvalid2, mready2, mlast2, ovalid2, oready2, olast2, und2, left2;
  logic [3:0] mdata2;
  sparse_mask_decomp #(.DATA_W(256), .ELEM_W(8)) u_dut (
    .axis_aclk(clk), .axis_areset(rst),
    .axis_tdata(tdata), .axis_tkeep(tkeep), .axis_tvalid(tvalid), .axis_tready(tready), .axis_tlast(tlast),
    .axis_mask_tdata(mdata), .axis_mask_tvalid(mvalid), .axis_mask_tready(mready), .axis_mask_tlast(mlast),
    .axis_tdata_c2s(odata), .axis_tkeep_c2s(okeep), .axis_tvalid_c2s(ovalid), .axis_tready_c2s(oready),
    .axis_tlast_c2s(olast), .err_underrun(und), .err_leftover(left));
  sparse_mask_decomp #(.DATA_W(128), .ELEM_W(32)) u_dut32 (
    .axis_aclk(clk), .axis_areset(rst),
    .axis_tdata(tdata2), .axis_tkeep(tkeep2), .axis_tvalid(tvalid2), .axis_tready(tready2), .axis_tlast(tlast2),
    .axis_mask_tdata(mdata2), .axis_mask_tvalid(mvalid2), .axis_mask_tready(mready2), .axis_mask_tlast(mlast2),
    .axis_tdata_c2s(odata2), .axis_tkeep_c2s(okeep2), .axis_tvalid_c2s(ovalid2), .axis_tready_c2s(oready2),
    .axis_tlast_c2s(olast2), .err_underrun(und2), .err_leftover(left2));
  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  beat_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  logic exp_und = 0, exp_left = 0;
  int rmode = 2;
  logic stall = 0, held_l;
  logic [DW-1:0] held;
  logic [7:0] e[$];
  logic [L-1:0] m[$];
  logic [31:0] w[6];
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    oready = 0;
    forever begin
      @(posedge clk);
      #1;
      oready = (rmode == 2) ? 1'b1 : (rmode == 1) ? ~oready : ($urandom_range(0, 3) != 0);
    end
  end
  initial forever begin
    beat_t b;
    @(negedge clk);
    if (rst) stall = 0;
    else begin
      if (stall) begin
        chk("hold_valid", DW'(ovalid), DW'(1));
        chk("hold_data", odata, held);
        chk("hold_last", DW'(olast), DW'(held_l));
      end
      if (ovalid && oready) begin
        if (exp_q.size() == 0) chk("extra_beat", DW'(exp_q.size()), DW'(1));
        else begin
          b = exp_q.pop_front();
          chk("out_data", odata, b.d);
          chk("out_last", DW'(olast), DW'(b.l));
          chk("out_keep", DW'(okeep), DW'({BW{1'b1}}));
        end
      end
      stall = ovalid && !oready;
      held = odata;
      held_l = olast;
    end
  end
  task automatic send_data(input logic [7:0] q[$]);
    int p, k, t;
    p = 0;
    @(posedge clk);
    #1;
    while (p < q.size()) begin
      k = (q.size() - p > L) ? L : q.size() - p;
      t = 0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      tdata = {8{$urandom}};
      tkeep = '0;
      for (int i = 0; i < k; i++) begin
        tdata[i*8 +: 8] = q[p+i];
        tkeep[i] = 1'b1;
      end
      tlast = (p + k == q.size());
      tvalid = 1;
      do begin @(negedge clk); t++; end while (!tready && t < 1000);
      chk("data_hs", DW'(tready), DW'(1));
      @(posedge clk);
      #1;
      tvalid = 0;
      tlast = 0;
      p += k;
    end
  endtask
  task automatic send_mask(input logic [L-1:0] q[$]);
    int t;
    @(posedge clk);
    #1;
    for (int i = 0; i < q.size(); i++) begin
      t = 0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      mdata = q[i];
      mlast = (i == q.size() - 1);
      mvalid = 1;
      do begin @(negedge clk); t++; end while (!mready && t < 1000);
      chk("mask_hs", DW'(mready), DW'(1));
      @(posedge clk);
      #1;
      mvalid = 0;
      mlast = 0;
    end
  endtask
  task automatic run_frame(input logic [7:0] q[$], input logic [L-1:0] mq[$]);
    int idx, t;
    beat_t b;
    idx = 0;
    for (int j = 0; j < mq.size(); j++) begin
      b.d = '0;
      for (int i = 0; i < L; i++)
        if (mq[j][i]) begin
          if (idx < q.size()) b.d[i*8 +: 8] = q[idx];
          else exp_und = 1;
          idx++;
        end
      b.l = (j == mq.size() - 1);
      exp_q.push_back(b);
    end
    if (idx < q.size()) exp_left = 1;
    fork
      send_data(q);
      send_mask(mq);
    join
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
    chk("drain", DW'(exp_q.size()), DW'(0));
    repeat (2) @(negedge clk);
    chk("err_underrun", DW'(und), DW'(exp_und));
    chk("err_leftover", DW'(left), DW'(exp_left));
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    exp_q.delete();
    exp_und = 0;
    exp_left = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask
  initial begin
    int tot;
    tdata = '0; tkeep = '0; tvalid = 0; tlast = 0; mdata = '0; mvalid = 0; mlast = 0;
    tdata2 = '0; tkeep2 = '0; tvalid2 = 0; tlast2 = 0; mdata2 = '0; mvalid2 = 0; mlast2 = 0; oready2 = 0;
    repeat (3) @(negedge clk);
    chk("rst_tready", DW'(tready), DW'(0));
    chk("rst_mready", DW'(mready), DW'(0));
    chk("rst_valid", DW'(ovalid), DW'(0));
    chk("rst_data", odata, '0);
    chk("rst_keep", DW'(okeep), '0);
    chk("rst_last", DW'(olast), DW'(0));
    chk("rst_errs", DW'({und, left}), DW'(0));
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("idle_tready", DW'(tready), DW'(1));
    e.delete(); m.delete();
    for (int i = 1; i <= 32; i++) e.push_back(8'(i));
    m.push_back('1);
    run_frame(e, m);
    e = '{8'hAA, 8'hBB, 8'hCC};
    m = '{32'h8000_0005};
    run_frame(e, m);
    rmode = 1;
    e.delete(); m.delete();
    for (int i = 0; i < 64; i++) e.push_back(8'($urandom_range(1, 255)));
    for (int i = 0; i < 16; i++) m.push_back(32'h0000_000F);
    run_frame(e, m);
    rmode = 0;
    for (int fr = 0; fr < 20; fr++) begin
      e.delete(); m.delete();
      tot = 0;
      for (int i = 0; i < $urandom_range(1, 6); i++) begin
        case ($urandom_range(0, 3))
          0: m.push_back('0);
          1: m.push_back('1);
          2: m.push_back($urandom);
          default: m.push_back($urandom & $urandom & $urandom);
        endcase
      end
      if (m[0] == '0) m[0] = 32'h1;
      foreach (m[i]) tot += $countones(m[i]);
      for (int i = 0; i < tot; i++) e.push_back(8'($urandom_range(1, 255)));
      run_frame(e, m);
    end
    e = '{8'h11, 8'h22, 8'h33};
    m = '{32'h0000_000F};
    run_frame(e, m);
    do_reset();
    e = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    m = '{32'h0000_0003};
    run_frame(e, m);
    e = '{8'h51, 8'h52, 8'h53};
    m = '{32'h0000_0101, 32'h0000_8000};
    run_frame(e, m);
    for (int i = 0; i < 6; i++) w[i] = $urandom | 32'h1;
    @(posedge clk);
    #1;
    tdata2 = {w[3], w[2], w[1], w[0]};
    tkeep2 = '1; tlast2 = 0; tvalid2 = 1; oready2 = 1;
    @(negedge clk);
    chk("t6_tready", DW'(tready2), DW'(1));
    @(posedge clk);
    #1;
    tvalid2 = 0; mdata2 = 4'b1010; mlast2 = 0; mvalid2 = 1;
    @(negedge clk);
    chk("t6_mready", DW'(mready2), DW'(1));
    @(posedge clk);
    #1;
    mvalid2 = 0; oready2 = 0;
    @(negedge clk);
    chk("t6_valid", DW'(ovalid2), DW'(1));
    chk("t6_data", DW'(odata2), DW'({w[1], 32'h0, w[0], 32'h0}));
    chk("t6_last", DW'(olast2), DW'(0));
    @(negedge clk);
    chk("t6_hold", DW'(odata2), DW'({w[1], 32'h0, w[0], 32'h0}));
    rst = 1;
    #1;
    chk("t6_rst_data", DW'(odata2), '0);
    chk("t6_rst_keep", DW'(okeep2), '0);
    chk("t6_rst_ctl", DW'({ovalid2, olast2, tready2, mready2, und2, left2}), '0);
    exp_q.delete();
    exp_und = 0;
    exp_left = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    tdata2 = {$urandom, $urandom, w[5], w[4]};
    tkeep2 = 16'h00FF; tlast2 = 1; tvalid2 = 1; mdata2 = 4'b0011; mlast2 = 1; oready2 = 1;
    @(negedge clk);
    chk("t6_tready2", DW'(tready2), DW'(1));
    @(posedge clk);
    #1;
    tvalid2 = 0; tlast2 = 0; mvalid2 = 1;
    @(negedge clk);
    chk("t6_mready2", DW'(mready2), DW'(1));
    @(posedge clk);
    #1;
    mvalid2 = 0;
    @(negedge clk);
    chk("t6_valid2", DW'(ovalid2), DW'(1));
    chk("t6_data2", DW'(odata2), DW'({64'h0, w[5], w[4]}));
    chk("t6_last2", DW'(olast2), DW'(1));
    chk("t6_errs2", DW'({und2, left2}), DW'(0));
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
